// File: rtl/axi4lite_mem_slave.sv
// AXI4-Lite word memory with byte strobes; writes commit on the AW/W pairing edge, B follows one cycle later.
// Reads answer RD_LATENCY cycles after AR; responses are held while B/R READY is low, and the matching channel then accepts nothing new.
module axi4lite_mem_slave #(
    parameter int XADDR_WIDTH = 32,
    parameter int XDATA_WIDTH = 32,
    parameter int XSTRB_WIDTH = 4,
    parameter int MEM_DEPTH   = 64,
    parameter logic [XADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int RD_LATENCY  = 1
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    input  logic                   AWVALID,
    output logic                   AWREADY,
    input  logic [XADDR_WIDTH-1:0] AWADDR,
    input  logic [2:0]             AWPROT,
    input  logic                   WVALID,
    output logic                   WREADY,
    input  logic [XDATA_WIDTH-1:0] WDATA,
    input  logic [XSTRB_WIDTH-1:0] WSTRB,
    output logic                   BVALID,
    input  logic                   BREADY,
    output logic [1:0]             BRESP,
    input  logic                   ARVALID,
    output logic                   ARREADY,
    input  logic [XADDR_WIDTH-1:0] ARADDR,
    input  logic [2:0]             ARPROT,
    output logic                   RVALID,
    input  logic                   RREADY,
    output logic [XDATA_WIDTH-1:0] RDATA,
    output logic [1:0]             RRESP
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [XADDR_WIDTH-1:0] MEM_BYTES = XADDR_WIDTH'(4 * MEM_DEPTH);
    localparam logic [3:0] LAT_LOAD = (RD_LATENCY > 1) ? 4'(RD_LATENCY - 2) : 4'd0;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_WAITW, W_WAITA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

    w_state_t w_state, w_state_nxt;
    r_state_t r_state, r_state_nxt;

    logic [XDATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                   rdy_en;
    logic [XADDR_WIDTH-1:0] aw_addr_q;
    logic [XDATA_WIDTH-1:0] w_data_q;
    logic [XSTRB_WIDTH-1:0] w_strb_q;
    logic [1:0]             bresp_q;
    logic [XDATA_WIDTH-1:0] rdata_q;
    logic [1:0]             rresp_q;
    logic [3:0]             lat_cnt;

    logic                   aw_hs, w_hs, ar_hs;
    logic                   commit;
    logic [XADDR_WIDTH-1:0] c_addr;
    logic [XDATA_WIDTH-1:0] c_data;
    logic [XSTRB_WIDTH-1:0] c_strb;
    logic                   c_hit, rd_hit;
    logic [IDX_W-1:0]       c_idx, rd_idx;

    wire unused_prot = ^{AWPROT, ARPROT};

    function automatic logic addr_hit(input logic [XADDR_WIDTH-1:0] addr);
        logic [XADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        return (addr >= BASE_ADDR) && (off < MEM_BYTES);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [XADDR_WIDTH-1:0] addr);
        logic [XADDR_WIDTH-1:0] off;
        off = (addr - BASE_ADDR) >> 2;
        return off[IDX_W-1:0];
    endfunction

    // Readies stay low through reset and come up on the first edge after release.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) rdy_en <= 1'b0;
        else       rdy_en <= 1'b1;
    end

    assign aw_hs = AWVALID & AWREADY;
    assign w_hs  = WVALID & WREADY;
    assign ar_hs = ARVALID & ARREADY;

    // ---------------- write channel ----------------
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) w_state <= W_IDLE;
        else       w_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = w_state;
        AWREADY     = 1'b0;
        WREADY      = 1'b0;
        BVALID      = 1'b0;
        commit      = 1'b0;
        c_addr      = AWADDR;
        c_data      = WDATA;
        c_strb      = WSTRB;
        case (w_state)
            W_IDLE: begin
                AWREADY = rdy_en;
                WREADY  = rdy_en;
                if (aw_hs && w_hs) begin
                    commit      = 1'b1;
                    w_state_nxt = W_RESP;
                end else if (aw_hs) begin
                    w_state_nxt = W_WAITW;
                end else if (w_hs) begin
                    w_state_nxt = W_WAITA;
                end
            end
            W_WAITW: begin
                WREADY = rdy_en;
                c_addr = aw_addr_q;
                if (w_hs) begin
                    commit      = 1'b1;
                    w_state_nxt = W_RESP;
                end
            end
            W_WAITA: begin
                AWREADY = rdy_en;
                c_data  = w_data_q;
                c_strb  = w_strb_q;
                if (aw_hs) begin
                    commit      = 1'b1;
                    w_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    assign c_hit = addr_hit(c_addr);
    assign c_idx = addr_idx(c_addr);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (w_state == W_IDLE && aw_hs && !w_hs) aw_addr_q <= AWADDR;
            if (w_state == W_IDLE && w_hs && !aw_hs) begin
                w_data_q <= WDATA;
                w_strb_q <= WSTRB;
            end
            if (commit) bresp_q <= c_hit ? RESP_OKAY : RESP_DECERR;
        end
    end

    assign BRESP = bresp_q;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else if (commit && c_hit) begin
            for (int b = 0; b < XSTRB_WIDTH; b++) begin
                if (c_strb[b]) mem[c_idx][8*b +: 8] <= c_data[8*b +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) r_state <= R_IDLE;
        else       r_state <= r_state_nxt;
    end

    always_comb begin
        r_state_nxt = r_state;
        ARREADY     = 1'b0;
        RVALID      = 1'b0;
        case (r_state)
            R_IDLE: begin
                ARREADY = rdy_en;
                if (ar_hs) r_state_nxt = (RD_LATENCY > 1) ? R_WAIT : R_DATA;
            end
            R_WAIT: begin
                if (lat_cnt == 4'd0) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                RVALID = 1'b1;
                if (RREADY) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    assign rd_hit = addr_hit(ARADDR);
    assign rd_idx = addr_idx(ARADDR);

    // Data is sampled at the AR edge, so a write committing on that same edge is not seen.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
            lat_cnt <= 4'd0;
        end else begin
            if (ar_hs) begin
                rdata_q <= rd_hit ? mem[rd_idx] : '0;
                rresp_q <= rd_hit ? RESP_OKAY : RESP_DECERR;
                lat_cnt <= LAT_LOAD;
            end else if (r_state == R_WAIT && lat_cnt != 4'd0) begin
                lat_cnt <= lat_cnt - 4'd1;
            end
        end
    end

    assign RDATA = rdata_q;
    assign RRESP = rresp_q;

endmodule

// File: tb/tb_axi4lite_mem_slave.sv
// Directed bench for axi4lite_mem_slave at default parameters (64 words at base 0, read latency 1).
module tb_axi4lite_mem_slave;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        AWVALID, AWREADY;
    logic [31:0] AWADDR;
    logic [2:0]  AWPROT;
    logic        WVALID, WREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        BVALID, BREADY;
    logic [1:0]  BRESP;
    logic        ARVALID, ARREADY;
    logic [31:0] ARADDR;
    logic [2:0]  ARPROT;
    logic        RVALID, RREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;

    int n_chk  = 0;
    int n_pass = 0;

    axi4lite_mem_slave dut (
        .CLK(CLK), .RSTN(RSTN),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // AW and W presented together, BREADY high.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [1:0] resp);
        AWVALID = 1'b1; AWADDR = addr;
        WVALID  = 1'b1; WDATA  = data; WSTRB = strb;
        BREADY  = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("wr_bvalid", BVALID, 1'b1);
        chk("wr_bresp", BRESP, resp);
        tick();
        chk("wr_bdone", {BVALID, AWREADY, WREADY}, 3'b011);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
        ARVALID = 1'b1; ARADDR = addr; RREADY = 1'b1;
        tick();
        ARVALID = 1'b0;
        chk("rd_valid", {RVALID, ARREADY}, 2'b10);
        chk("rd_data", RDATA, data);
        chk("rd_resp", RRESP, resp);
        tick();
        chk("rd_done", {RVALID, ARREADY}, 2'b01);
    endtask

    initial begin
        RSTN = 1'b0;
        AWVALID = 0; AWADDR = 0; AWPROT = 0;
        WVALID = 0; WDATA = 0; WSTRB = 0; BREADY = 0;
        ARVALID = 0; ARADDR = 0; ARPROT = 0; RREADY = 0;

        tick(); tick();
        chk("rst_outs", {AWREADY, WREADY, ARREADY, BVALID, RVALID}, 5'b0);
        chk("rst_resp", {BRESP, RRESP, RDATA}, 36'h0);
        RSTN = 1'b1;
        #1;
        chk("rst_rel_rdy_low", {AWREADY, WREADY, ARREADY}, 3'b000);
        tick();
        chk("rst_rel_rdy_up", {AWREADY, WREADY, ARREADY}, 3'b111);

        // Same-cycle write and read-back
        wr(32'h08, 32'hDEADBEEF, 4'hF, 2'b00);
        rd(32'h08, 32'hDEADBEEF, 2'b00);

        // W first, AW three cycles later, partial strobe
        wr(32'h0C, 32'hAABBCCDD, 4'hF, 2'b00);
        WVALID = 1'b1; WDATA = 32'h11223344; WSTRB = 4'b0101; BREADY = 1'b1;
        tick();
        WVALID = 1'b0;
        chk("waita_rdy", {AWREADY, WREADY, BVALID}, 3'b100);
        tick(); tick();
        chk("waita_hold", {AWREADY, WREADY, BVALID}, 3'b100);
        AWVALID = 1'b1; AWADDR = 32'h0C;
        tick();
        AWVALID = 1'b0;
        chk("waita_b", {BVALID, BRESP}, 3'b100);
        tick();
        rd(32'h0C, 32'hAA22CC44, 2'b00);

        // AW first, W next cycle
        AWVALID = 1'b1; AWADDR = 32'h14;
        tick();
        AWVALID = 1'b0;
        chk("waitw_rdy", {AWREADY, WREADY, BVALID}, 3'b010);
        WVALID = 1'b1; WDATA = 32'h12345678; WSTRB = 4'hF;
        tick();
        WVALID = 1'b0;
        chk("waitw_b", {BVALID, BRESP}, 3'b100);
        tick();
        rd(32'h14, 32'h12345678, 2'b00);

        // Zero strobe: OKAY, no change
        wr(32'h08, 32'h0, 4'h0, 2'b00);
        rd(32'h08, 32'hDEADBEEF, 2'b00);

        // Range boundaries
        wr(32'hFC, 32'hCAFEF00D, 4'hF, 2'b00);
        rd(32'hFC, 32'hCAFEF00D, 2'b00);
        wr(32'h100, 32'hFFFFFFFF, 4'hF, 2'b11);
        rd(32'h100, 32'h0, 2'b11);
        rd(32'h00, 32'h0, 2'b00);

        // Back-pressure on both response channels for five cycles
        AWVALID = 1'b1; AWADDR = 32'h200; WVALID = 1'b1; WDATA = 32'h1; WSTRB = 4'hF;
        ARVALID = 1'b1; ARADDR = 32'h08;
        BREADY = 1'b0; RREADY = 1'b0;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ctl", {BVALID, BRESP, RVALID, RRESP, AWREADY, WREADY, ARREADY}, 9'b1_11_1_00_000);
            chk("bp_rdata", RDATA, 32'hDEADBEEF);
            tick();
        end
        BREADY = 1'b1; RREADY = 1'b1;
        tick();
        chk("bp_release", {BVALID, RVALID, AWREADY, WREADY, ARREADY}, 5'b00111);

        // Read sampled on the same edge as a committing write
        AWVALID = 1'b1; AWADDR = 32'h10; WVALID = 1'b1; WDATA = 32'h5; WSTRB = 4'hF;
        ARVALID = 1'b1; ARADDR = 32'h10;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        chk("race_valids", {BVALID, RVALID}, 2'b11);
        chk("race_old", RDATA, 32'h0);
        tick();
        rd(32'h10, 32'h5, 2'b00);

        // Asynchronous reset with both responses pending
        AWVALID = 1'b1; AWADDR = 32'h18; WVALID = 1'b1; WDATA = 32'h77; WSTRB = 4'hF;
        ARVALID = 1'b1; ARADDR = 32'h08;
        BREADY = 1'b0; RREADY = 1'b0;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        chk("pre_rst", {BVALID, RVALID}, 2'b11);
        #2 RSTN = 1'b0;
        #1;
        chk("async_rst", {BVALID, RVALID, AWREADY, WREADY, ARREADY}, 5'b0);
        chk("async_rst_d", {BRESP, RRESP, RDATA}, 36'h0);
        tick();
        RSTN = 1'b1;
        #1;
        chk("rel_rdy_low", {AWREADY, WREADY, ARREADY}, 3'b000);
        tick();
        chk("rel_rdy_up", {AWREADY, WREADY, ARREADY, BVALID, RVALID}, 5'b11100);
        rd(32'h08, 32'h0, 2'b00);
        rd(32'h18, 32'h0, 2'b00);
        rd(32'h10, 32'h0, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
